retire_sync_n: RTL and testbench



---
 rtl/retire_sync_n.sv | 193 +++++++++++++++++++
 tb/tb_retire_sync_n.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_sync_n.sv
// ---------------------------------------------------------------------------
// RetireSyncN (module retire_sync_n)
//
// Aligns instruction retirement across N_COPIES core instances that run the
// same program for relational contract checking. Each copy gets its own
// clock enable. A copy may run up to MAX_SKEW retirements ahead of the
// slowest copy before its enable is dropped. Once every copy has retired the
// same instruction index, one aligned retire pulse is produced.
//
// If some retirement stays unmatched for TIMEOUT cycles, a copy is assumed to
// be stuck. The block then latches a sticky desync flag and freezes every copy
// until reset. TIMEOUT = 0 disables this check.
//
// Parameters:
//   N_COPIES  number of core copies (2..8)
//   MAX_SKEW  retirements a copy may lead the slowest copy by (>= 1);
//             1 gives lock-step behaviour
//   TIMEOUT   cycles of unmatched retirement before desync (0 = off)
//
// Ports:
//   clk_i        main verification clock
//   rst_i        asynchronous reset, active-high
//   retire_i     per-copy retire strobe; bit k only counts while enable_o[k]=1
//   halt_i       freeze request from the control block
//   enable_o     per-copy clock enable (combinational)
//   retire_o     aligned retire pulse, one cycle per aligned instruction
//   timeout_o    sticky desync flag
//   pend_max_o   largest per-copy pending count, for debug
//
// Optional build macro RETIRE_SYNC_STATS_EN adds:
//   stall_cnt_o  N_COPIES x 32-bit saturating counts of RUN cycles in which a
//                copy was held back by skew (slice k = copy k)
//   align_cnt_o  32-bit saturating count of aligned retire pulses
// ---------------------------------------------------------------------------
module retire_sync_n #(
    parameter int N_COPIES = 2,
    parameter int MAX_SKEW = 1,
    parameter int TIMEOUT  = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [N_COPIES-1:0]               retire_i,
    input  logic                              halt_i,
    output logic [N_COPIES-1:0]               enable_o,
    output logic                              retire_o,
    output logic                              timeout_o,
    output logic [$clog2(MAX_SKEW+1)-1:0]     pend_max_o
`ifdef RETIRE_SYNC_STATS_EN
    ,
    output logic [N_COPIES*32-1:0]            stall_cnt_o,
    output logic [31:0]                       align_cnt_o
`endif
);

    localparam int PW = $clog2(MAX_SKEW + 1);
    // The timer needs at least one bit even when the timeout is disabled.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_DESYNC
    } state_t;

    state_t            state;
    logic [PW-1:0]     pend     [N_COPIES];
    logic [PW-1:0]     avail    [N_COPIES];
    logic [PW-1:0]     pend_nxt [N_COPIES];
    logic [PW-1:0]     max_nxt;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_nxt;
    logic [N_COPIES-1:0] inc;
    logic [N_COPIES-1:0] has_avail;
    logic              align;
    logic              any_avail;
    logic              desync_hit;

    // A copy is enabled only while running, not halted, and still below its
    // skew allowance. Because the enable drops at MAX_SKEW, the pending count
    // can never overflow.
    always_comb begin
        enable_o = '0;
        for (int k = 0; k < N_COPIES; k++) begin
            enable_o[k] = (state == ST_RUN) && !halt_i && (pend[k] < PW'(MAX_SKEW));
        end
    end

    // Alignment happens when every copy has at least one retirement available.
    // That covers one already pending, one arriving this cycle, or both.
    // Alignment consumes one retirement from each copy. The timer runs only
    // while some retirement is waiting and nothing aligns.
    always_comb begin
        inc       = retire_i & enable_o;
        has_avail = '0;
        for (int k = 0; k < N_COPIES; k++) begin
            avail[k]     = pend[k] + PW'(inc[k]);
            has_avail[k] = (avail[k] != '0);
        end
        align     = &has_avail;
        any_avail = |has_avail;

        max_nxt = '0;
        for (int k = 0; k < N_COPIES; k++) begin
            pend_nxt[k] = align ? (avail[k] - 1'b1) : avail[k];
            if (pend_nxt[k] > max_nxt) begin
                max_nxt = pend_nxt[k];
            end
        end

        if (align || !any_avail) begin
            timer_nxt = '0;
        end else if (timer == TW'(TIMEOUT)) begin
            timer_nxt = timer;
        end else begin
            timer_nxt = timer + 1'b1;
        end

        desync_hit = (TIMEOUT != 0) && !align && (timer_nxt == TW'(TIMEOUT));
    end

    // Main control. Halting freezes the pending counts and the timer
    // untouched. Desync is terminal until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_RUN;
            timer      <= '0;
            retire_o   <= 1'b0;
            timeout_o  <= 1'b0;
            pend_max_o <= '0;
            for (int k = 0; k < N_COPIES; k++) begin
                pend[k] <= '0;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_i) begin
                        state    <= ST_HALT;
                        retire_o <= 1'b0;
                    end else begin
                        for (int k = 0; k < N_COPIES; k++) begin
                            pend[k] <= pend_nxt[k];
                        end
                        timer      <= timer_nxt;
                        retire_o   <= align;
                        pend_max_o <= max_nxt;
                        if (desync_hit) begin
                            state     <= ST_DESYNC;
                            timeout_o <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    retire_o <= 1'b0;
                    if (!halt_i) begin
                        state <= ST_RUN;
                    end
                end
                ST_DESYNC: begin
                    retire_o  <= 1'b0;
                    timeout_o <= 1'b1;
                end
                default: begin
                    state    <= ST_RUN;
                    retire_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef RETIRE_SYNC_STATS_EN
    // Stall counters count only cycles in which skew, and not halt or
    // desync, is what holds a copy back. All counters saturate rather than
    // wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            align_cnt_o <= '0;
        end else if (state == ST_RUN && !halt_i) begin
            for (int k = 0; k < N_COPIES; k++) begin
                if (pend[k] >= PW'(MAX_SKEW) && stall_cnt_o[k*32 +: 32] != 32'hFFFF_FFFF) begin
                    stall_cnt_o[k*32 +: 32] <= stall_cnt_o[k*32 +: 32] + 32'd1;
                end
            end
            if (align && align_cnt_o != 32'hFFFF_FFFF) begin
                align_cnt_o <= align_cnt_o + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_retire_sync_n.sv
// ---------------------------------------------------------------------------
// Testbench for retire_sync_n (N_COPIES=3, MAX_SKEW=2, TIMEOUT=16).
//
// The reference model tracks the total number of retirements per copy and
// the number of aligned instructions. Each pending count is the difference
// between the two. Directed scenarios run first: simultaneous retire, skew
// limit, halt, timeout, and asynchronous reset. A randomized phase follows,
// with a varying retire bias, halts and occasional resets.
// ---------------------------------------------------------------------------
module tb_retire_sync_n;

    localparam int N    = 3;
    localparam int SKEW = 2;
    localparam int TMO  = 16;
    localparam int PW   = $clog2(SKEW + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          halt;
    logic [N-1:0]  retire;
    logic [N-1:0]  enable;
    logic          ret_o;
    logic          tmo_o;
    logic [PW-1:0] pmax;
`ifdef RETIRE_SYNC_STATS_EN
    logic [N*32-1:0] stall;
    logic [31:0]     alignc;
`endif

    int checks = 0;
    int fails  = 0;

    // Reference model state
    int   retired [N];
    int   aligned;
    int   timer;
    int   mstate;       // 0 = running, 1 = halted, 2 = desynchronised
    logic exp_retire;
    logic exp_timeout;

    retire_sync_n #(
        .N_COPIES(N),
        .MAX_SKEW(SKEW),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .retire_i   (retire),
        .halt_i     (halt),
        .enable_o   (enable),
        .retire_o   (ret_o),
        .timeout_o  (tmo_o),
        .pend_max_o (pmax)
`ifdef RETIRE_SYNC_STATS_EN
        ,
        .stall_cnt_o(stall),
        .align_cnt_o(alignc)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] modelEnable(input logic h);
        logic [N-1:0] en;
        en = '0;
        for (int k = 0; k < N; k++) begin
            en[k] = (mstate == 0) && !h && ((retired[k] - aligned) < SKEW);
        end
        return en;
    endfunction

    function automatic int modelPendMax();
        int m;
        m = 0;
        for (int k = 0; k < N; k++) begin
            if (retired[k] - aligned > m) m = retired[k] - aligned;
        end
        return m;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < N; k++) retired[k] = 0;
        aligned     = 0;
        timer       = 0;
        mstate      = 0;
        exp_retire  = 1'b0;
        exp_timeout = 1'b0;
    endtask

    task automatic modelStep(input logic [N-1:0] accepted, input logic h);
        int  minr;
        logic waiting;
        case (mstate)
            0: begin
                if (h) begin
                    mstate     = 1;
                    exp_retire = 1'b0;
                end else begin
                    for (int k = 0; k < N; k++) if (accepted[k]) retired[k]++;
                    minr    = retired[0];
                    waiting = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (retired[k] < minr) minr = retired[k];
                        if (retired[k] > aligned) waiting = 1'b1;
                    end
                    if (minr > aligned) begin
                        aligned++;
                        exp_retire = 1'b1;
                        timer      = 0;
                    end else begin
                        exp_retire = 1'b0;
                        if (waiting) timer = (timer < TMO) ? timer + 1 : TMO;
                        else         timer = 0;
                        if (TMO != 0 && timer == TMO) begin
                            mstate      = 2;
                            exp_timeout = 1'b1;
                        end
                    end
                end
            end
            1: begin
                exp_retire = 1'b0;
                if (!h) mstate = 0;
            end
            default: exp_retire = 1'b0;
        endcase
    endtask

    // One clock cycle: drive inputs, compare every output, then advance model.
    task automatic applyStimulus(input logic [N-1:0] r, input logic h);
        logic [N-1:0] en;
        @(negedge clk);
        retire = r;
        halt   = h;
        #1;
        en = modelEnable(h);
        checkOutput("enable_o",   32'(enable), 32'(en));
        checkOutput("retire_o",   32'(ret_o),  32'(exp_retire));
        checkOutput("timeout_o",  32'(tmo_o),  32'(exp_timeout));
        checkOutput("pend_max_o", 32'(pmax),   32'(modelPendMax()));
        @(posedge clk);
        modelStep(r & en, h);
    endtask

    // Reset asserted between clock edges; outputs must clear immediately.
    task automatic doReset();
        @(negedge clk);
        retire = '0;
        halt   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_timeout_o", 32'(tmo_o),  32'd0);
        checkOutput("rst_enable_o",  32'(enable), 32'h7);
        checkOutput("rst_retire_o",  32'(ret_o),  32'd0);
        checkOutput("rst_pend_max",  32'(pmax),   32'd0);
`ifdef RETIRE_SYNC_STATS_EN
        checkOutput("rst_stall_cnt", 32'(stall != '0), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    int prob [N];
    int desync_cycles;

    initial begin
        rst    = 1'b1;
        halt   = 1'b0;
        retire = '0;
        modelReset();
        #12;
        checkOutput("reset_enable_o",  32'(enable), 32'h7);
        checkOutput("reset_retire_o",  32'(ret_o),  32'd0);
        checkOutput("reset_timeout_o", 32'(tmo_o),  32'd0);
        checkOutput("reset_pend_max",  32'(pmax),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] simultaneous retirement");
        repeat (4) applyStimulus(3'b111, 1'b0);
        repeat (2) applyStimulus(3'b000, 1'b0);

        $display("[TB] skew limit on copy 0");
        repeat (3) applyStimulus(3'b001, 1'b0);
        #1;
        checkOutput("skew_enable0", 32'(enable[0]), 32'd0);
        checkOutput("skew_pend_max", 32'(pmax), 32'd2);
        applyStimulus(3'b110, 1'b0);
        applyStimulus(3'b000, 1'b0);

        $display("[TB] halt with copy 0 pending");
        repeat (10) applyStimulus(3'b111, 1'b1);
        applyStimulus(3'b000, 1'b0);
        applyStimulus(3'b110, 1'b0);
        repeat (2) applyStimulus(3'b000, 1'b0);

        $display("[TB] timeout on a stuck copy");
        applyStimulus(3'b001, 1'b0);
        repeat (18) applyStimulus(3'b000, 1'b0);
        #1;
        checkOutput("desync_flag",   32'(tmo_o),  32'd1);
        checkOutput("desync_enable", 32'(enable), 32'd0);
        applyStimulus(3'b110, 1'b0);
        applyStimulus(3'b000, 1'b1);
        applyStimulus(3'b000, 1'b0);
        doReset();

        $display("[TB] randomized phase");
        desync_cycles = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [N-1:0] r;
            logic h;
            if (cyc % 150 == 0) begin
                for (int k = 0; k < N; k++) prob[k] = 20 + int'($urandom_range(70));
                if ($urandom_range(3) == 0) prob[$urandom_range(N - 1)] = 0;
            end
            for (int k = 0; k < N; k++) r[k] = (int'($urandom_range(99)) < prob[k]);
            h = ($urandom_range(99) < 4);
            applyStimulus(r, h);
            desync_cycles = (mstate == 2) ? desync_cycles + 1 : 0;
            if (desync_cycles > 3 || $urandom_range(199) == 0) begin
                doReset();
                desync_cycles = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
